// File: rtl/dms_if.sv
// dms_if: serial line in, decoded message and configuration status out
interface dms_if;
    logic str;
    logic mode;
    logic msg;
    logic msg_valid;
    logic frame;
    logic cfg_done;
    logic cfg_err;
    modport master (output str, mode, input msg, msg_valid, frame, cfg_done, cfg_err);
    modport slave (input str, mode, output msg, msg_valid, frame, cfg_done, cfg_err);
endinterface

// File: rtl/dms_decoder.sv
// dms_decoder: serially configured duty-cycle symbol decoder with cycling XOR key and force-one mask
module dms_decoder #(
    parameter int N_W = 4,
    parameter int KEY_LOG2_MAX = 5,
    parameter int CNT_W = 16,
    parameter int MIN_SYM = 2
) (
    input  logic clk,
    input  logic reset,
    dms_if.slave bus
);
    localparam int KMAX = 2 ** KEY_LOG2_MAX;
    localparam int BC_W = $clog2((KMAX > N_W) ? KMAX : N_W) + 1;

    typedef enum logic [2:0] {IDLE, CFG_N, CFG_D, CFG_M, CFG_HOLD, DEC_SYNC, DEC_RUN} state_t;

    state_t                  state_q, state_d;
    logic [N_W-1:0]          n_q, n_d, n_nxt;
    logic [KMAX-1:0]         key_q, key_d, caps_q, caps_d;
    logic [BC_W-1:0]         bcnt_q, bcnt_d, last_cnt;
    logic [CNT_W-1:0]        ones_q, ones_d, zeros_q, zeros_d;
    logic [CNT_W:0]          sym_len;
    logic [KEY_LOG2_MAX-1:0] kidx_q, kidx_d, kmax_idx;
    logic [KEY_LOG2_MAX:0]   len_l;
    logic                    prev_q, prev_d, msg_q, msg_d, valid_q, valid_d, frame_q, frame_d;
    logic                    done_q, done_d, err_q, err_d;
    logic                    in_cfg, go_dec, cfg_abort, rise;

    assign len_l     = (KEY_LOG2_MAX + 1)'(1) << n_q;
    assign last_cnt  = BC_W'(len_l - 1'b1);
    assign kmax_idx  = KEY_LOG2_MAX'(len_l - 1'b1);
    assign n_nxt     = {n_q[N_W-2:0], bus.str};
    assign sym_len   = {1'b0, ones_q} + {1'b0, zeros_q};
    assign in_cfg    = state_q inside {CFG_N, CFG_D, CFG_M, CFG_HOLD};
    assign cfg_abort = !bus.mode && (state_q inside {CFG_N, CFG_D, CFG_M});
    assign go_dec    = !bus.mode && done_q && (state_q == IDLE || state_q == CFG_HOLD);
    assign rise      = !prev_q && bus.str;

    assign bus.msg       = msg_q;
    assign bus.msg_valid = valid_q;
    assign bus.frame     = frame_q;
    assign bus.cfg_done  = done_q;
    assign bus.cfg_err   = err_q;

    // next-state: config shifting, decode sync, symbol measurement and decryption
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        key_d   = key_q;
        caps_d  = caps_q;
        bcnt_d  = bcnt_q;
        ones_d  = ones_q;
        zeros_d = zeros_q;
        prev_d  = prev_q;
        kidx_d  = kidx_q;
        msg_d   = msg_q;
        valid_d = 1'b0;
        frame_d = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        if (bus.mode && !in_cfg) begin
            state_d = CFG_N;
            done_d  = 1'b0;
            err_d   = 1'b0;
            key_d   = '0;
            caps_d  = '0;
            n_d     = N_W'(bus.str);
            bcnt_d  = BC_W'(1);
        end else if (go_dec) begin
            state_d = DEC_SYNC;
            prev_d  = 1'b0;
            ones_d  = '0;
            zeros_d = '0;
            kidx_d  = kmax_idx;
        end else if (cfg_abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                CFG_N: begin
                    n_d    = n_nxt;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BC_W'(N_W - 1)) begin
                        bcnt_d  = '0;
                        err_d   = n_nxt > N_W'(KEY_LOG2_MAX);
                        state_d = (n_nxt > N_W'(KEY_LOG2_MAX)) ? IDLE : CFG_D;
                    end
                end
                CFG_D: begin
                    key_d   = {key_q[KMAX-2:0], bus.str};
                    bcnt_d  = (bcnt_q == last_cnt) ? '0 : bcnt_q + 1'b1;
                    state_d = (bcnt_q == last_cnt) ? CFG_M : CFG_D;
                end
                CFG_M: begin
                    caps_d  = {caps_q[KMAX-2:0], bus.str};
                    bcnt_d  = (bcnt_q == last_cnt) ? '0 : bcnt_q + 1'b1;
                    done_d  = bcnt_q == last_cnt;
                    state_d = (bcnt_q == last_cnt) ? CFG_HOLD : CFG_M;
                end
                DEC_SYNC: begin
                    prev_d = bus.str;
                    if (rise) begin
                        state_d = DEC_RUN;
                        ones_d  = CNT_W'(1);
                        zeros_d = '0;
                    end
                end
                DEC_RUN: begin
                    prev_d = bus.str;
                    if (rise) begin
                        ones_d  = CNT_W'(1);
                        zeros_d = '0;
                        if (sym_len >= (CNT_W + 1)'(MIN_SYM)) begin
                            msg_d   = ((ones_q >= zeros_q) ^ key_q[kidx_q]) | caps_q[kidx_q];
                            valid_d = 1'b1;
                            frame_d = kidx_q == '0;
                            kidx_d  = (kidx_q == '0) ? kmax_idx : kidx_q - 1'b1;
                        end
                    end else if (bus.str) begin
                        ones_d = (ones_q == '1) ? ones_q : ones_q + 1'b1;
                    end else begin
                        zeros_d = (zeros_q == '1) ? zeros_q : zeros_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            key_q   <= '0;
            caps_q  <= '0;
            bcnt_q  <= '0;
            ones_q  <= '0;
            zeros_q <= '0;
            prev_q  <= 1'b0;
            kidx_q  <= '0;
            msg_q   <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            key_q   <= key_d;
            caps_q  <= caps_d;
            bcnt_q  <= bcnt_d;
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            prev_q  <= prev_d;
            kidx_q  <= kidx_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
